// File: rtl/pea_cfg_loader.sv
// PEA configuration loader: streams one word per PE into a shadow bank,
// checks select fields and commits a clean load atomically to the active bank.
module pea_cfg_loader #(
  parameter int N_PE  = 16,
  parameter int CFG_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    cfg_valid_i,
  input  logic [CFG_W-1:0]        cfg_data_i,
  output logic                    cfg_ready_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [$clog2(N_PE)-1:0] err_idx_o,
  output logic                    cfg_update_o,
  output logic [N_PE*CFG_W-1:0]   pe_cfg_o
);

  localparam int IW = $clog2(N_PE);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_e;

  state_e                  state_q;
  logic [IW-1:0]           cnt_q;
  logic [IW-1:0]           err_idx_q;
  logic                    err_flag_q;
  logic                    err_q;
  logic                    done_q;
  logic                    upd_q;
  logic [CFG_W-1:0]        shadow_q [N_PE];
  logic [N_PE*CFG_W-1:0]   active_q;
  logic                    accept;
  logic                    illegal;

  assign cfg_ready_o  = (state_q == LOAD);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_idx_o    = err_idx_q;
  assign cfg_update_o = upd_q;
  assign pe_cfg_o     = active_q;

  // abort wins over a simultaneous handshake
  assign accept  = cfg_ready_o & cfg_valid_i & ~abort_i;
  assign illegal = (cfg_data_i[7:4] > 4'd8)
                 | (cfg_data_i[11:8] > 4'd8)
                 | (&cfg_data_i[14:12]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_idx_q  <= '0;
      err_flag_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      upd_q      <= 1'b0;
      active_q   <= '0;
    end else begin
      done_q <= 1'b0;
      upd_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
            err_flag_q <= 1'b0;
          end
        end
        LOAD: begin
          if (abort_i) begin
            state_q    <= IDLE;
            err_flag_q <= 1'b0;
          end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (illegal && !err_flag_q) begin
              err_flag_q <= 1'b1;
              err_idx_q  <= cnt_q;
            end
            if (cnt_q == IW'(N_PE - 1)) begin
              state_q <= COMMIT;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (err_flag_q) begin
            err_q <= 1'b1;
          end else begin
            upd_q <= 1'b1;
            for (int k = 0; k < N_PE; k++) begin
              active_q[k*CFG_W +: CFG_W] <= shadow_q[k];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // shadow contents only matter during a load, so no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      shadow_q[cnt_q] <= cfg_data_i;
    end
  end

endmodule

// File: tb/tb_pea_cfg_loader.sv
// Directed, table-driven bench for pea_cfg_loader.
// Load scenarios come from a vector table; abort and reset are hand sequences.
module tb_pea_cfg_loader;

  localparam int NP = 16;
  localparam int W  = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic            abort;
  logic            valid;
  logic [W-1:0]    data;
  logic            ready;
  logic            busy;
  logic            done;
  logic            err;
  logic [3:0]      err_idx;
  logic            upd;
  logic [NP*W-1:0] pe_cfg;

  pea_cfg_loader #(.N_PE(NP), .CFG_W(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .cfg_valid_i (valid),
    .cfg_data_i  (data),
    .cfg_ready_o (ready),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_idx_o   (err_idx),
    .cfg_update_o(upd),
    .pe_cfg_o    (pe_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP*W-1:0] words;
    bit              stall;
    logic            exp_err;
    logic [3:0]      exp_idx;
  } vec_t;

  vec_t            tbl [7];
  int              n_vec = 0;
  int              n_bad = 0;
  logic [NP*W-1:0] exp_act;

  task automatic chk(input string nm, input logic [NP*W-1:0] act,
                     input logic [NP*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // called #1 after a rising edge with the DUT in IDLE
  task automatic run_load(input vec_t v, input string tag);
    int i;
    int cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " ready s+1"}, ready, 1'b1);
    chk({tag, " busy s+1"}, busy, 1'b1);
    chk({tag, " err clr"}, err, 1'b0);
    chk({tag, " idx clr"}, err_idx, 4'd0);
    i = 0;
    cyc = 0;
    while (i < NP && cyc < 400) begin
      valid = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      data  = v.words[i*W +: W];
      @(posedge clk);
      if (valid) i++;
      #1;
      cyc++;
    end
    valid = 1'b0;
    if (i < NP) chk({tag, " load timeout"}, i, NP);
    chk({tag, " busy t+1"}, busy, 1'b1);
    chk({tag, " ready t+1"}, ready, 1'b0);
    chk({tag, " done t+1"}, done, 1'b0);
    @(posedge clk); #1;
    if (!v.exp_err) exp_act = v.words;
    chk({tag, " done t+2"}, done, 1'b1);
    chk({tag, " upd t+2"}, upd, !v.exp_err);
    chk({tag, " busy t+2"}, busy, 1'b0);
    chk({tag, " err"}, err, v.exp_err);
    chk({tag, " err_idx"}, err_idx, v.exp_idx);
    chk({tag, " pe_cfg"}, pe_cfg, exp_act);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, done, 1'b0);
    chk({tag, " upd pulse"}, upd, 1'b0);
    chk({tag, " err sticky"}, err, v.exp_err);
  endtask

  initial begin
    for (int k = 0; k < NP; k++) begin
      tbl[0].words[k*W +: W] = 32'(k);
      tbl[1].words[k*W +: W] = 32'(k);
      tbl[2].words[k*W +: W] = {16'hC000 + 16'(k), 16'hE881};
      tbl[3].words[k*W +: W] = 32'h0000_0011 | (32'(k) << 16);
      tbl[4].words[k*W +: W] = 32'hABCD_0888;
      tbl[5].words[k*W +: W] = 32'h5A5A_0000 + 32'(k);
      tbl[6].words[k*W +: W] = 32'h0000_8003 | (32'(k) << 16);
    end
    tbl[1].words[5*W +: W]  = 32'h0000_0090;
    tbl[1].words[9*W +: W]  = 32'h0000_7009;
    tbl[3].words[15*W +: W] = 32'h0000_0900;
    tbl[4].words[0*W +: W]  = 32'h0000_7000;
    tbl[4].words[3*W +: W]  = 32'h0000_00F0;
    tbl[0].stall = 0; tbl[0].exp_err = 0; tbl[0].exp_idx = 4'd0;
    tbl[1].stall = 1; tbl[1].exp_err = 1; tbl[1].exp_idx = 4'd5;
    tbl[2].stall = 1; tbl[2].exp_err = 0; tbl[2].exp_idx = 4'd0;
    tbl[3].stall = 0; tbl[3].exp_err = 1; tbl[3].exp_idx = 4'd15;
    tbl[4].stall = 0; tbl[4].exp_err = 1; tbl[4].exp_idx = 4'd0;
    tbl[5].stall = 0; tbl[5].exp_err = 0; tbl[5].exp_idx = 4'd0;
    tbl[6].stall = 1; tbl[6].exp_err = 0; tbl[6].exp_idx = 4'd0;

    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; data = '0;
    exp_act = '0;
    #12;
    chk("rst pe_cfg", pe_cfg, '0);
    chk("rst ready", ready, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst idx", err_idx, 4'd0);
    chk("rst upd", upd, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    valid = 1'b1;
    data  = 32'h1111_1111;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle ready", ready, 1'b0);
      chk("idle busy", busy, 1'b0);
    end
    valid = 1'b0;

    for (int v = 0; v < 5; v++) run_load(tbl[v], $sformatf("vec%0d", v));

    // abort on word 7 with an illegal word earlier in the load
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      valid = 1'b1;
      data  = (k == 2) ? 32'h0000_7000 : 32'(k);
      @(posedge clk); #1;
    end
    valid = 1'b1; abort = 1'b1; data = 32'd7;
    @(posedge clk); #1;
    valid = 1'b0; abort = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort ready", ready, 1'b0);
    repeat (3) begin
      chk("abort done", done, 1'b0);
      chk("abort upd", upd, 1'b0);
      chk("abort err", err, 1'b0);
      chk("abort pe_cfg", pe_cfg, exp_act);
      @(posedge clk); #1;
    end
    run_load(tbl[5], "reload");

    // asynchronous reset after word 10
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      valid = 1'b1;
      data  = 32'hDEAD_0000 + 32'(k);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_act = '0;
    chk("arst pe_cfg", pe_cfg, '0);
    chk("arst busy", busy, 1'b0);
    chk("arst ready", ready, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst upd", upd, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_load(tbl[6], "postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pea_cfg_loader.md
# pea_cfg_loader

Configuration writer for the processing element array (PEA). It accepts a stream of 32-bit PE configuration words over a valid/ready handshake and checks each word's operand- and delay-select fields against the legal encodings. Words land in a shadow bank; a complete, error-free load is committed atomically to the active bank that drives every PE's configuration register. It sits between the host/DMA configuration path and the M×N PE grid, and produces exactly what the PEs decode.

## Interface

Parameters:
- N_PE, default 16 (M*N): number of PEs; one configuration word per PE (N_CFG_REGS_PE = 1).
- CFG_W, default 32 (N_CFG_BITS_PE): configuration word width.

Ports:
- clk_i, input, 1: single clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- start_i, input, 1: begin a load; sampled only in IDLE.
- abort_i, input, 1: cancel an in-progress load.
- cfg_valid_i, input, 1: configuration word valid.
- cfg_data_i, input, CFG_W: configuration word. Field layout:
  - [3:0] fu_instr: opcode; all 16 codes legal.
  - [7:4] operand A select.
  - [11:8] operand B select.
  - [14:12] delay select.
  - [15] reserved; ignored and stored as written.
  - [31:16] constant.
- cfg_ready_o, output, 1: loader accepts a word this cycle.
- busy_o, output, 1: state is not IDLE.
- done_o, output, 1: one-cycle pulse at the end of a load, whether it succeeded or failed.
- err_o, output, 1: last load had an illegal word. Sticky until the next accepted start_i.
- err_idx_o, output, $clog2(N_PE): PE index of the first illegal word.
- cfg_update_o, output, 1: one-cycle pulse; the active bank changed this cycle.
- pe_cfg_o, output, N_PE*CFG_W: active configuration; PE k occupies bits [k*CFG_W +: CFG_W].

## Operation

- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - cfg_ready_o = 0.
  - If start_i = 1: go to LOAD, clear the word counter, err_o and err_idx_o.
- LOAD:
  - cfg_ready_o = 1.
  - On cfg_valid_i & cfg_ready_o: write the word to shadow[cnt] and increment cnt.
  - When the accepted word has cnt == N_PE-1: go to COMMIT.
- Legality check, applied to every accepted word:
  - Operand A or B select > 4'd8 (i.e. 9..15) is illegal.
  - Delay select == 3'b111 is illegal.
  - On the first illegal word of a load, set an internal error flag and capture cnt into err_idx_o.
  - Later illegal words do not change err_idx_o.
  - Words are still accepted after an error, so the producer always drains N_PE words.
- COMMIT (one cycle, cfg_ready_o = 0):
  - If no error: active ← shadow, cfg_update_o pulses, done_o pulses.
  - If error: active is unchanged, err_o is set, done_o pulses, cfg_update_o stays 0.
  - Then return to IDLE.
- abort_i:
  - Honoured in LOAD only, with priority over a simultaneous handshake.
  - The word presented that cycle is not accepted; the state returns to IDLE.
  - The active bank is untouched; no done_o; the error flag is discarded and err_o stays 0.
- start_i in LOAD or COMMIT is ignored.
- Shadow contents are don't-care outside LOAD; pe_cfg_o reflects only the active bank.

## Timing

- Reset values:
  - State IDLE.
  - cfg_ready_o = 0, busy_o = 0, done_o = 0, err_o = 0, err_idx_o = 0, cfg_update_o = 0.
  - pe_cfg_o all zeros (every PE at NOP, STREAM_IN0 selects, constant 0).
- Reset is asynchronous and may hit mid-LOAD: all of the above are restored immediately and the partial load is lost.
- cfg_ready_o is derived from registered state only; there is no combinational path from cfg_valid_i.
- Cycle-level sequence, cycle numbers counted from the cycle in which start_i is sampled high in IDLE:
  - Cycle s: start_i = 1 in IDLE.
  - Cycle s+1: cfg_ready_o = 1.
  - The full load takes N_PE handshake cycles; a back-to-back load of 16 words occupies cycles s+1..s+16.
  - Cycle t: last word accepted.
  - Cycle t+1: COMMIT, busy_o = 1, cfg_ready_o = 0.
  - Cycle t+2: new pe_cfg_o visible, done_o = 1, cfg_update_o = 1 (success only), busy_o = 0.
  - The earliest next start_i is sampled in cycle t+2.
- done_o and cfg_update_o are registered and high for exactly one cycle.
- err_o and err_idx_o are stable from cycle t+2 until the next accepted start_i.

## Test plan

- Reset then idle: after rst_i, pe_cfg_o = 0, cfg_ready_o = 0, busy_o = 0; cfg_valid_i pulses in IDLE are not accepted.
- Clean load: start_i, then 16 back-to-back words 0x0000_0000+k (k = 0..15, all legal) → done_o and cfg_update_o high at cycle t+2; pe_cfg_o[k*32 +: 32] = k; err_o = 0.
- Illegal select with drain: word 5 = 0x0000_0090 (operand A select = 9) and word 9 delay select = 7 → all 16 words accepted; done_o pulses; err_o = 1, err_idx_o = 5; pe_cfg_o keeps the previous values; no cfg_update_o.
- Stalled producer: random cfg_valid_i gaps on a 16-word load → exactly 16 words written in order; done_o two cycles after the 16th handshake.
- Abort: abort_i together with cfg_valid_i on word 7 → word 7 not accepted; IDLE next cycle; no done_o; pe_cfg_o unchanged. A new start_i then reloads all 16 words cleanly.
- Async reset mid-load: rst_i pulsed after word 10 → outputs return to zero immediately; a subsequent full load commits normally.
